// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared lane state type, escape threshold and fixed-point helpers
package mandelbrot_pkg;
    typedef enum logic [1:0] {IDLE, ITER, DONE} lane_state_t;
    function automatic logic [127:0] esc_thresh(input int frac);
        return 128'd4 << (2 * frac);
    endfunction
    function automatic logic signed [127:0] fx_mul(input logic signed [63:0] x, input logic signed [63:0] y);
        return x * y;
    endfunction
    function automatic logic signed [127:0] fx_shr(input logic signed [127:0] x, input int frac);
        return x >>> frac;
    endfunction
endpackage

// File: rtl/mandelbrot_lane.sv
// mandelbrot_lane: one iteration lane (FSM, complex square-and-add datapath, counter)
module mandelbrot_lane import mandelbrot_pkg::*; #(
    parameter int BIT_WIDTH  = 32,
    parameter int FRAC_BITS  = 24,
    parameter int ITER_WIDTH = 16,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  julia_i,
    input  logic                  ack_i,
    input  logic [BIT_WIDTH-1:0]  re_i,
    input  logic [BIT_WIDTH-1:0]  im_i,
    input  logic [BIT_WIDTH-1:0]  jre_i,
    input  logic [BIT_WIDTH-1:0]  jim_i,
    input  logic [ITER_WIDTH-1:0] lim_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  idle_o,
    output logic                  done_o,
    output logic [ITER_WIDTH-1:0] iter_o,
    output logic                  esc_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);
    localparam int PW = 2 * BIT_WIDTH;
    lane_state_t st_q;
    logic signed [BIT_WIDTH-1:0] a_q, b_q, cr_q, ci_q;
    logic [BIT_WIDTH-1:0] a_d, b_d;
    logic [ITER_WIDTH-1:0] k_q, lim_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic esc_q, esc;
    logic signed [PW-1:0] aa, bb, ab, dr;
    logic signed [PW:0] ab2;
    logic [PW:0] mag;
    assign aa  = PW'(fx_mul(64'(a_q), 64'(a_q)));
    assign bb  = PW'(fx_mul(64'(b_q), 64'(b_q)));
    assign ab  = PW'(fx_mul(64'(a_q), 64'(b_q)));
    // squares are non-negative, so the magnitude sum fits one extra bit unsigned
    assign mag = {1'b0, aa} + {1'b0, bb};
    assign esc = mag > (PW+1)'(esc_thresh(FRAC_BITS));
    assign dr  = aa - bb;
    assign ab2 = {ab, 1'b0};
    assign a_d = BIT_WIDTH'(fx_shr(128'(dr), FRAC_BITS)) + cr_q;
    assign b_d = BIT_WIDTH'(fx_shr(128'(ab2), FRAC_BITS)) + ci_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cr_q  <= '0;
            ci_q  <= '0;
            k_q   <= '0;
            lim_q <= '0;
            tag_q <= '0;
            esc_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE: if (start_i) begin
                    st_q  <= ITER;
                    a_q   <= julia_i ? re_i : '0;
                    b_q   <= julia_i ? im_i : '0;
                    cr_q  <= julia_i ? jre_i : re_i;
                    ci_q  <= julia_i ? jim_i : im_i;
                    k_q   <= '0;
                    lim_q <= lim_i;
                    tag_q <= tag_i;
                end
                ITER: if (esc || k_q == lim_q) begin
                    st_q  <= DONE;
                    esc_q <= esc;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    k_q <= k_q + 1'b1;
                end
                DONE: if (ack_i) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end
    assign idle_o = st_q == IDLE;
    assign done_o = st_q == DONE;
    assign iter_o = k_q;
    assign esc_o  = esc_q;
    assign tag_o  = tag_q;
endmodule

// File: rtl/mandelbrot_multi_engine.sv
// mandelbrot_multi_engine: NUM_LANES Mandelbrot/Julia lanes with dispatcher and round-robin output
module mandelbrot_multi_engine import mandelbrot_pkg::*; #(
    parameter int BIT_WIDTH  = 32,
    parameter int FRAC_BITS  = 24,
    parameter int NUM_LANES  = 4,
    parameter int ITER_WIDTH = 16,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_WIDTH-1:0]  in_re,
    input  logic [BIT_WIDTH-1:0]  in_im,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic                  julia_mode,
    input  logic [BIT_WIDTH-1:0]  julia_re,
    input  logic [BIT_WIDTH-1:0]  julia_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_iter,
    output logic                  out_escaped,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    logic [NUM_LANES-1:0] idle, done, start, ack, cand;
    logic [ITER_WIDTH-1:0] l_iter [NUM_LANES];
    logic [TAG_WIDTH-1:0] l_tag [NUM_LANES];
    logic l_esc [NUM_LANES];
    logic [LW-1:0] dsel, pick, gnt_q, ptr_q;
    logic found, hs, load;
    logic out_valid_q, out_esc_q;
    logic [ITER_WIDTH-1:0] out_iter_q;
    logic [TAG_WIDTH-1:0] out_tag_q;
    assign in_ready = |idle;
    assign busy     = ~&idle;
    assign hs       = out_valid_q && out_ready;
    assign load     = !out_valid_q || out_ready;
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign start[g] = in_valid && in_ready && dsel == LW'(g);
        assign ack[g]   = hs && gnt_q == LW'(g);
        // the lane leaving on this handshake must not be granted again
        assign cand[g]  = done[g] && !ack[g];
        mandelbrot_lane #(
            .BIT_WIDTH(BIT_WIDTH), .FRAC_BITS(FRAC_BITS),
            .ITER_WIDTH(ITER_WIDTH), .TAG_WIDTH(TAG_WIDTH)
        ) u_lane (
            .clk(clk), .rst(rst), .start_i(start[g]), .julia_i(julia_mode), .ack_i(ack[g]),
            .re_i(in_re), .im_i(in_im), .jre_i(julia_re), .jim_i(julia_im),
            .lim_i(max_iter), .tag_i(in_tag), .idle_o(idle[g]), .done_o(done[g]),
            .iter_o(l_iter[g]), .esc_o(l_esc[g]), .tag_o(l_tag[g])
        );
    end
    always_comb begin
        dsel = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) dsel = idle[i] ? LW'(i) : dsel;
    end
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_LANES; i >= 1; i--) begin
            if (cand[LW'((int'(ptr_q) + i) % NUM_LANES)]) begin
                found = 1'b1;
                pick  = LW'((int'(ptr_q) + i) % NUM_LANES);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_iter_q  <= '0;
            out_esc_q   <= 1'b0;
            out_tag_q   <= '0;
            gnt_q       <= '0;
            ptr_q       <= LW'(NUM_LANES - 1);
        end else if (load) begin
            out_valid_q <= found;
            if (found) begin
                gnt_q      <= pick;
                ptr_q      <= pick;
                out_iter_q <= l_iter[pick];
                out_esc_q  <= l_esc[pick];
                out_tag_q  <= l_tag[pick];
            end
        end
    end
    assign out_valid   = out_valid_q;
    assign out_iter    = out_iter_q;
    assign out_escaped = out_esc_q;
    assign out_tag     = out_tag_q;
endmodule

// File: tb/tb_mandelbrot_multi_engine.sv
// tb_mandelbrot_multi_engine: directed and random checks against an arithmetic reference model
module tb_mandelbrot_multi_engine;
    localparam int BW = 32, FB = 24, NL = 4, IW = 16, TW = 20;
    localparam logic [BW-1:0] TWO = 32'h0200_0000, THREE = 32'h0300_0000;
    logic clk = 0, rst = 1, in_valid = 0, julia_mode = 0, out_ready = 0;
    logic in_ready, out_valid, out_escaped, busy;
    logic [BW-1:0] in_re = '0, in_im = '0, julia_re = '0, julia_im = '0;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic [IW-1:0] max_iter = '0, out_iter;
    int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, rise_cyc = 0;
    logic ready_val = 0, rr_mode = 0, ov_prev = 0;
    logic [TW-1:0] got_tags[$];
    logic [IW-1:0] last_iter = '0;
    logic last_esc = 0;
    logic exp_pend [256];
    logic [IW-1:0] exp_iter [256];
    logic exp_esc [256];

    mandelbrot_multi_engine #(.BIT_WIDTH(BW), .FRAC_BITS(FB), .NUM_LANES(NL),
                              .ITER_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_tag(in_tag), .max_iter(max_iter),
        .julia_mode(julia_mode), .julia_re(julia_re), .julia_im(julia_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter),
        .out_escaped(out_escaped), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #2;
        out_ready = rr_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    task automatic check(input string name, input longint obs, input longint expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", name, obs, expv);
        end
    endtask

    function automatic logic signed [127:0] wrap(input logic signed [127:0] x);
        logic signed [BW-1:0] t;
        t = x[BW-1:0];
        return t;
    endfunction

    // unbounded-precision escape-time iteration, result = {iter, escaped}
    function automatic logic [IW:0] ref_pt(input bit jm, input logic signed [BW-1:0] re, im,
                                           jre, jim, input int lim);
        logic signed [127:0] a, b, cr, ci, aa, bb, ab;
        if (jm) begin a = re; b = im; cr = jre; ci = jim; end
        else begin a = 0; b = 0; cr = re; ci = im; end
        for (int k = 0; k <= lim; k++) begin
            aa = a * a; bb = b * b; ab = a * b;
            if (aa + bb > (128'sd4 <<< (2 * FB))) return {IW'(k), 1'b1};
            if (k == lim) return {IW'(lim), 1'b0};
            a = wrap(((aa - bb) >>> FB) + cr);
            b = wrap(((2 * ab) >>> FB) + ci);
        end
        return '0;
    endfunction

    always @(negedge clk) begin
        if (out_valid && !ov_prev) rise_cyc = cyc;
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
            got_tags.push_back(out_tag);
            last_iter = out_iter;
            last_esc = out_escaped;
            check("tag_pending", exp_pend[out_tag[7:0]], 1);
            check("sb_iter", out_iter, exp_iter[out_tag[7:0]]);
            check("sb_esc", out_escaped, exp_esc[out_tag[7:0]]);
            exp_pend[out_tag[7:0]] = 0;
        end
    end

    task automatic send(input bit jm, input logic [BW-1:0] re, im, jre, jim, input int lim, input int tag);
        logic [IW:0] r;
        int n = 0;
        in_valid = 1; julia_mode = jm; in_re = re; in_im = im;
        julia_re = jre; julia_im = jim; max_iter = IW'(lim); in_tag = TW'(tag);
        r = ref_pt(jm, re, im, jre, jim, lim);
        exp_iter[tag] = r[IW:1]; exp_esc[tag] = r[0]; exp_pend[tag] = 1;
        @(negedge clk);
        while (!in_ready && n < 300) begin n++; @(negedge clk); end
        check("accept", in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 0;
    endtask

    task automatic wait_n(input int n, input int budget);
        int c = 0;
        while (got_tags.size() < n && c < budget) begin @(posedge clk); #1; c++; end
        check("out_count", got_tags.size(), n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [BW-1:0] rnd(input int half);
        return BW'(int'($urandom_range(0, 2 * half)) - half);
    endfunction

    initial begin
        int pend;
        for (int i = 0; i < 256; i++) begin exp_pend[i] = 0; exp_iter[i] = '0; exp_esc[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_iter", out_iter, 0);
        check("rst_out_escaped", out_escaped, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        rst = 0; ready_val = 1;
        idle(1);

        send(0, TWO, TWO, '0, '0, 100, 5);
        wait_n(1, 50);
        check("c22_latency", rise_cyc - acc_cyc, 3);
        check("c22_tag", got_tags[0], 5);
        check("c22_iter", last_iter, 1);
        check("c22_esc", last_esc, 1);
        got_tags.delete();

        send(0, '0, '0, '0, '0, 20, 6);
        wait_n(1, 60);
        check("c0_latency", rise_cyc - acc_cyc, 22);
        check("c0_iter", last_iter, 20);
        check("c0_esc", last_esc, 0);
        got_tags.delete();

        send(1, THREE, '0, '0, '0, 10, 7);
        wait_n(1, 50);
        check("julia3_latency", rise_cyc - acc_cyc, 2);
        check("julia3_iter", last_iter, 0);
        check("julia3_esc", last_esc, 1);
        got_tags.delete();
        send(1, '0, '0, '0, '0, 0, 8);
        wait_n(1, 50);
        check("lim0_iter", last_iter, 0);
        check("lim0_esc", last_esc, 0);
        got_tags.delete();

        send(0, '0, '0, '0, '0, 50, 0);
        send(0, '0, '0, '0, '0, 50, 1);
        send(0, TWO, TWO, '0, '0, 50, 2);
        send(0, TWO, TWO, '0, '0, 50, 3);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        @(posedge clk); #1;
        send(0, TWO, TWO, '0, '0, 50, 4);
        wait_n(5, 200);
        for (int i = 0; i < 5; i++) check("ooo_order", got_tags[i], i == 0 ? 2 : i == 1 ? 3 : i == 2 ? 4 : i - 3);
        got_tags.delete();

        ready_val = 0;
        idle(1);
        for (int i = 0; i < 4; i++) send(0, TWO, TWO, '0, '0, 50, 10 + i);
        idle(5);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_tag_t0", out_tag, 10);
        idle(10);
        @(negedge clk);
        check("hold_tag_t10", out_tag, 10);
        check("hold_iter_t10", out_iter, 1);
        check("hold_esc_t10", out_escaped, 1);
        check("hold_valid_t10", out_valid, 1);
        check("hold_busy", busy, 1);
        check("hold_no_emit", got_tags.size(), 0);
        @(posedge clk); #1;
        ready_val = 1;
        wait_n(4, 50);
        for (int i = 0; i < 4; i++) check("rr_order", got_tags[i], 10 + i);
        got_tags.delete();

        for (int i = 0; i < 3; i++) send(0, '0, '0, '0, '0, 200, 20 + i);
        rst = 1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 20; i < 23; i++) exp_pend[i] = 0;
        send(0, TWO, TWO, '0, '0, 100, 23);
        wait_n(1, 50);
        check("post_rst_tag", got_tags[0], 23);
        check("post_rst_iter", last_iter, 1);
        idle(30);
        check("post_rst_no_stale", got_tags.size(), 1);
        got_tags.delete();

        rr_mode = 1;
        for (int i = 0; i < 30; i++)
            send(1'($urandom_range(0, 1)), rnd(3 << FB), rnd(3 << FB), rnd(1 << FB), rnd(1 << FB),
                 int'($urandom_range(0, 40)), 100 + i);
        wait_n(30, 8000);
        rr_mode = 0;
        idle(5);
        pend = 0;
        for (int i = 0; i < 256; i++) pend += int'(exp_pend[i]);
        check("all_drained", pend, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mandelbrot_multi_engine.md
Name: mandelbrot_multi_engine

Overview:
- Parametrised successor to the single-point Mandelbrot iterator, with NUM_LANES independent fixed-point iteration lanes behind one valid/ready input and one valid/ready output.
- Adds a runtime iteration limit, Julia mode and per-point tags.
- Results may complete out of order; the tag identifies the pixel.
- Sits between the pixel-coordinate generator and the colour/frame-buffer writer.

Parameters:
BIT_WIDTH, 32, total width of signed fixed-point coordinates
FRAC_BITS, 24, fractional bits (Q(BIT_WIDTH-FRAC_BITS).FRAC_BITS)
NUM_LANES, 4, number of parallel iteration lanes (1..16)
ITER_WIDTH, 16, width of iteration counter and max_iter
TAG_WIDTH, 20, width of pixel tag carried with each point

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  point presented
in_ready  out  1  engine accepts point this cycle
in_re  in  BIT_WIDTH  real coordinate (signed fixed-point)
in_im  in  BIT_WIDTH  imaginary coordinate
in_tag  in  TAG_WIDTH  opaque pixel identifier
max_iter  in  ITER_WIDTH  iteration limit, sampled at accept
julia_mode  in  1  0 = Mandelbrot, 1 = Julia; sampled at accept
julia_re  in  BIT_WIDTH  Julia constant real part, sampled at accept
julia_im  in  BIT_WIDTH  Julia constant imaginary part, sampled at accept
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_iter  out  ITER_WIDTH  iterations completed before escape or limit
out_escaped  out  1  1 = escaped, 0 = hit max_iter
out_tag  out  TAG_WIDTH  tag of the result
busy  out  1  any lane not IDLE

Behaviour:
- Reset: all lanes IDLE, in-flight points dropped. in_ready=1, out_valid=0, out_iter=0, out_escaped=0, out_tag=0, busy=0. Asserting reset mid-iteration aborts immediately.
- Lane FSM: IDLE -> ITER on accept; ITER -> DONE on terminate; DONE -> IDLE on output handshake.
- Accept: occurs when in_valid && in_ready. The point goes to the lowest-index IDLE lane.
- in_ready = any lane IDLE at the start of the cycle. A lane freed by this cycle's output handshake is not reusable until the next cycle, so there is no combinational path from out_ready to in_ready.
- Accepted values:
  - Mandelbrot: z0=0, c=(in_re,in_im).
  - Julia: z0=(in_re,in_im), c=(julia_re,julia_im).
  - k=0; lim=max_iter.
- ITER cycle with count k:
  - Compute a²,b²,ab as full 2*BIT_WIDTH signed products.
  - Escape test: a²+b² > 4<<(2*FRAC_BITS), evaluated at 2*BIT_WIDTH+1 bits with no truncation.
  - If escape: DONE with iter=k, escaped=1.
  - Else if k==lim: DONE with iter=lim, escaped=0.
  - Else:
    - a' = (a²-b²)>>>FRAC_BITS + c_re
    - b' = (2ab)>>>FRAC_BITS + c_im
    - Both truncated to BIT_WIDTH with two's-complement wrap; k++.
- max_iter=0: the first ITER cycle terminates with iter=0, escaped = result of the escape test on z0.
- Latency: accept at edge 0; a point terminating at count k raises out_valid k+2 cycles after accept.
- One iteration per lane per cycle. Throughput is up to NUM_LANES points in flight.
- Output arbiter: round-robin among DONE lanes, with the pointer starting after the last granted lane.
  - Once out_valid is asserted, the granted lane and out_iter/out_escaped/out_tag stay stable until out_ready.
  - The grant may not switch while the handshake is pending.
- Back-pressure: DONE lanes hold their results indefinitely. When all lanes are DONE, in_ready=0.
- Simultaneous accept and output handshake in the same cycle are both legal and independent.
- busy = any lane in ITER or DONE.

Decomposition:
- mandelbrot_pkg holds:
  - lane_state_t enum (IDLE, ITER, DONE)
  - escape-threshold constant function of FRAC_BITS
  - fixed-point multiply/shift helper functions
- Sub-module mandelbrot_lane: one lane's FSM, datapath and counter. Instantiated NUM_LANES times via generate.
- The top level holds the dispatcher (priority encoder), the round-robin output arbiter and the output mux.

Test Plan:
- Mandelbrot c=(2.0,2.0), max_iter=100, tag=5 -> out_iter=1, out_escaped=1, out_tag=5, out_valid 3 cycles after accept.
- Mandelbrot c=(0,0), max_iter=20 -> out_iter=20, out_escaped=0, out_valid 22 cycles after accept.
- Julia z0=(3.0,0), const=(0,0), max_iter=10 -> out_iter=0, out_escaped=1. With max_iter=0 and z0=(0,0) -> out_iter=0, out_escaped=0.
- NUM_LANES=4, send c=0 (limit 50) to tags 0,1 then c=(2,2) to tags 2,3, out_ready=1 -> tags 2,3 emitted before tags 0,1. 5th point stalls (in_ready=0) until a lane frees.
- Hold out_ready=0 with all lanes DONE -> in_ready=0, out_* stable for 10 cycles. Release out_ready -> round-robin emits lanes in order 0,1,2,3 with no duplicates or loss.
- Assert rst while 3 lanes are in ITER -> next cycle out_valid=0, busy=0, in_ready=1. A new point afterwards completes correctly with no stale results.
